// File: rtl/onehot_encoder.sv
// onehot_encoder: sequential 4-to-2 encoder. Captures one-cycle event pulses
// on REQ_IN as sticky pending bits and emits one 2-bit code per event through
// a valid/ready output stage. Simultaneous events are arbitrated round-robin
// (ROUND_ROBIN=1) or by fixed priority, lowest code first (ROUND_ROBIN=0).
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   REQ_IN   in   [3:0] event pulses, bit i = one event for code i
//   VAL_OUT  out  [1:0] code held in the output stage (registered)
//   VALID    out  output stage holds an event (registered)
//   READY    in   consumer accepts VAL_OUT this cycle when VALID=1
//   PENDING  out  [3:0] captured events not yet loaded (registered)
//   OVERFLOW out  one-cycle pulse, a duplicate event was dropped (registered)
module onehot_encoder #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ_IN,
  output logic [1:0] VAL_OUT,
  output logic       VALID,
  input  logic       READY,
  output logic [3:0] PENDING,
  output logic       OVERFLOW
);

  localparam int unsigned N_CODES = 4;
  localparam int unsigned CODE_W  = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CODE_W-1:0]  code_q,  code_d;
  logic [CODE_W-1:0]  ptr_q,   ptr_d;
  logic [N_CODES-1:0] pend_q,  pend_d;
  logic               ovf_q,   ovf_d;

  logic [N_CODES-1:0] cand;
  logic               sel_found;
  logic [CODE_W-1:0]  sel_idx;
  logic [CODE_W-1:0]  scan_idx;
  logic               load;

  // New requests bypass the pending register straight into selection.
  assign cand = pend_q | REQ_IN;

  // Pick the winning candidate: scan from PTR (wrapping) or from code 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_CODES; k++) begin
      if (ROUND_ROBIN != 0) begin
        scan_idx = ptr_q + CODE_W'(k);
      end else begin
        scan_idx = CODE_W'(k);
      end
      if (!sel_found && cand[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      code_q  <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: load the output stage whenever it is free or draining.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    load    = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (READY) begin
          if (sel_found) begin
            load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (load) begin
      code_d = sel_idx;
      // PTR only matters in round-robin mode; tracking it always is harmless.
      ptr_d  = sel_idx + CODE_W'(1);
    end

    // The loaded event leaves PENDING; everything else stays captured.
    if (load) begin
      pend_d = cand & ~(N_CODES'(1) << sel_idx);
    end else begin
      pend_d = cand;
    end

    // A request that is already pending is a dropped duplicate, even if that
    // pending bit is being loaded on this same edge.
    ovf_d = |(REQ_IN & pend_q);
  end

  assign VALID    = (state_q == ST_FULL);
  assign VAL_OUT  = code_q;
  assign PENDING  = pend_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Testbench for onehot_encoder: two instances (round-robin and fixed
// priority) share stimulus. A behavioural model predicts each cycle and
// pushes expectations into queues that a separate monitor pops and compares.
module tb_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic [1:0] val_rr, val_fp;
  logic       valid_rr, valid_fp;
  logic [3:0] pend_rr, pend_fp;
  logic       ovf_rr, ovf_fp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  onehot_encoder #(.ROUND_ROBIN(1)) dut_rr (
    .CLK(clk), .RST(rst), .REQ_IN(req), .VAL_OUT(val_rr), .VALID(valid_rr),
    .READY(ready), .PENDING(pend_rr), .OVERFLOW(ovf_rr)
  );

  onehot_encoder #(.ROUND_ROBIN(0)) dut_fp (
    .CLK(clk), .RST(rst), .REQ_IN(req), .VAL_OUT(val_fp), .VALID(valid_fp),
    .READY(ready), .PENDING(pend_fp), .OVERFLOW(ovf_fp)
  );

  // Per-cycle expectation for the status outputs.
  typedef struct {
    bit       v;
    bit [3:0] p;
    bit       o;
  } exp_t;

  exp_t cyc_q0[$];
  exp_t cyc_q1[$];
  int   code_q0[$];
  int   code_q1[$];

  // Model state; index 0 = round-robin instance, 1 = fixed priority.
  bit mpend [2][4];
  bit mvalid[2];
  int mptr  [2];
  int held  [2];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) mpend[m][i] = 1'b0;
      mvalid[m] = 1'b0;
      mptr[m]   = 0;
      held[m]   = 0;
    end
    cyc_q0.delete();
    cyc_q1.delete();
    code_q0.delete();
    code_q1.delete();
  endfunction

  // One clock of the behavioural encoder for instance m.
  function automatic void model_step(input int m, input logic [3:0] r, input bit rdy);
    bit   cand[4];
    bit   ovf;
    int   c;
    int   start;
    exp_t e;
    ovf = 1'b0;
    c   = -1;
    for (int i = 0; i < 4; i++) begin
      cand[i] = mpend[m][i] | r[i];
      if (r[i] && mpend[m][i]) ovf = 1'b1;
    end
    if (!mvalid[m] || rdy) begin
      start = (m == 0) ? mptr[m] : 0;
      for (int k = 0; k < 4; k++) begin
        if (c < 0 && cand[(start + k) % 4]) c = (start + k) % 4;
      end
      if (c >= 0) begin
        mvalid[m] = 1'b1;
        if (m == 0) mptr[m] = (c + 1) % 4;
        cand[c] = 1'b0;
        if (m == 0) code_q0.push_back(c);
        else        code_q1.push_back(c);
      end else begin
        mvalid[m] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      mpend[m][i] = cand[i];
      e.p[i]      = cand[i];
    end
    e.v = mvalid[m];
    e.o = ovf;
    if (m == 0) cyc_q0.push_back(e);
    else        cyc_q1.push_back(e);
  endfunction

  // Drive one cycle of stimulus and advance the model.
  task automatic step(input logic [3:0] r, input bit rdy);
    @(negedge clk);
    req   = r;
    ready = rdy;
    model_step(0, r, rdy);
    model_step(1, r, rdy);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst   = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    model_step(0, 4'b0000, 1'b0);
    model_step(1, 4'b0000, 1'b0);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic check_dut(input int m, input bit prev, output bit now_v);
    string tag;
    bit    v;
    int    code;
    int    p;
    bit    o;
    exp_t  e;
    int    c;
    tag  = (m == 0) ? "rr" : "fp";
    v    = (m == 0) ? valid_rr : valid_fp;
    code = (m == 0) ? int'(val_rr) : int'(val_fp);
    p    = (m == 0) ? int'(pend_rr) : int'(pend_fp);
    o    = (m == 0) ? ovf_rr : ovf_fp;
    now_v = v;
    if ((m == 0 ? cyc_q0.size() : cyc_q1.size()) == 0) begin
      check({tag, " expectation available"}, 0, 1);
      return;
    end
    e = (m == 0) ? cyc_q0.pop_front() : cyc_q1.pop_front();
    check({tag, " VALID"}, int'(v), int'(e.v));
    check({tag, " PENDING"}, p, int'(e.p));
    check({tag, " OVERFLOW"}, int'(o), int'(e.o));
    if (v && (!prev || ready)) begin
      if ((m == 0 ? code_q0.size() : code_q1.size()) == 0) begin
        check({tag, " code expected"}, 0, 1);
      end else begin
        c = (m == 0) ? code_q0.pop_front() : code_q1.pop_front();
        check({tag, " VAL_OUT load"}, code, c);
        held[m] = c;
      end
    end else if (v) begin
      check({tag, " VAL_OUT hold"}, code, held[m]);
    end
  endtask

  // Monitor: after every edge, compare outputs against queued expectations.
  initial begin
    bit prev_v[2];
    bit nv;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          check_dut(m, prev_v[m], nv);
          prev_v[m] = nv;
        end
      end
    end
  end

  initial begin
    int exp_pend[4];
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    release_reset();
    repeat (2) step(4'b0000, 1'b1);

    // Single event.
    step(4'b0100, 1'b1);
    peek();
    check("single VALID", int'(valid_rr), 1);
    check("single VAL_OUT", int'(val_rr), 2);
    check("single PENDING", int'(pend_rr), 0);
    step(4'b0000, 1'b1);
    peek();
    check("single VALID drop", int'(valid_rr), 0);

    // Serve code 11 alone so the round-robin pointer wraps to 0.
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);

    // Burst of all four codes.
    exp_pend[0] = 4'b1110;
    exp_pend[1] = 4'b1100;
    exp_pend[2] = 4'b1000;
    exp_pend[3] = 4'b0000;
    step(4'b1111, 1'b1);
    peek();
    check("burst VAL_OUT 0", int'(val_rr), 0);
    check("burst PENDING 0", int'(pend_rr), exp_pend[0]);
    for (int i = 1; i < 4; i++) begin
      step(4'b0000, 1'b1);
      peek();
      check("burst VAL_OUT", int'(val_rr), i);
      check("burst PENDING", int'(pend_rr), exp_pend[i]);
    end
    step(4'b0000, 1'b1);
    peek();
    check("burst VALID drop", int'(valid_rr), 0);

    // Backpressure.
    step(4'b0010, 1'b0);
    repeat (5) step(4'b0000, 1'b0);
    peek();
    check("bp VAL_OUT stable", int'(val_rr), 1);
    step(4'b1000, 1'b0);
    peek();
    check("bp PENDING", int'(pend_rr), 4'b1000);
    step(4'b0000, 1'b1);
    peek();
    check("bp next code", int'(val_rr), 3);
    repeat (3) step(4'b0000, 1'b1);

    // Overflow: the same code requested while already pending.
    repeat (3) step(4'b0001, 1'b0);
    peek();
    check("ovf pulse", int'(ovf_rr), 1);
    step(4'b0000, 1'b0);
    peek();
    check("ovf one cycle", int'(ovf_rr), 0);
    repeat (4) step(4'b0000, 1'b1);

    // Arbitration after serving code 00 alone.
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0101, 1'b1);
    peek();
    check("arb rr first", int'(val_rr), 2);
    check("arb fp first", int'(val_fp), 0);
    step(4'b0000, 1'b1);
    peek();
    check("arb rr second", int'(val_rr), 0);
    check("arb fp second", int'(val_fp), 2);
    repeat (2) step(4'b0000, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      step(4'($urandom & $urandom), ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset in the middle of a cycle with work in flight.
    step(4'b0001, 1'b0);
    step(4'b1011, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst VALID rr", int'(valid_rr), 0);
    check("rst VAL_OUT rr", int'(val_rr), 0);
    check("rst PENDING rr", int'(pend_rr), 0);
    check("rst OVERFLOW rr", int'(ovf_rr), 0);
    check("rst VALID fp", int'(valid_fp), 0);
    check("rst PENDING fp", int'(pend_fp), 0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    repeat (3) step(4'b0000, 1'b1);

    // More random traffic after reset, then drain.
    for (int n = 0; n < 500; n++) begin
      step(4'($urandom & $urandom), ($urandom_range(0, 9) < 5));
    end
    repeat (8) step(4'b0000, 1'b1);
    peek();
    check("leftover rr cycles", cyc_q0.size(), 0);
    check("leftover fp cycles", cyc_q1.size(), 0);
    check("leftover rr codes", code_q0.size(), 0);
    check("leftover fp codes", code_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onehot_encoder.md
# onehot_encoder

Sequential 4-to-2 encoder: the inverse of the 2-to-4 decoder. It collects per-code event pulses on four request lines, e.g. per-quadrant or per-neighbour-class events from the cell grid, and holds them as sticky pending bits. It emits each event as a 2-bit code through a valid/ready output stage, arbitrating simultaneous events round-robin or by fixed priority. It sits between event-generating grid logic and any single-code consumer such as a status/update sequencer.

## Interface
- ROUND_ROBIN, default 1: 1 = round-robin arbitration among pending codes; 0 = fixed priority, lowest code wins.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_IN  in  4  event pulses; bit i set for one cycle = one event for code i (2'b00..2'b11).
- VAL_OUT  out  2  encoded code of the event in the output stage; registered.
- VALID  out  1  output stage holds an event; registered.
- READY  in  1  consumer accepts VAL_OUT this cycle when VALID=1.
- PENDING  out  4  sticky pending vector (events captured, not yet loaded to output); registered.
- OVERFLOW  out  1  one-cycle pulse: an event was lost; registered.

## Operation
- State: PEND[3:0], output stage {VALID, VAL_OUT}, pointer PTR[1:0] (round-robin start; unused when ROUND_ROBIN=0).
- Candidate vector CAND = PEND | REQ_IN. REQ_IN bypasses PEND into selection.
- Output stage is loadable when VALID=0 or (VALID=1 and READY=1).
- Selection, when loadable and CAND!=0:
  - ROUND_ROBIN=1: first set bit of CAND scanning PTR, PTR+1, ... mod 4.
  - ROUND_ROBIN=0: lowest set index.
  - Selected index c goes to VAL_OUT. VALID becomes 1. If round-robin, PTR becomes c+1 mod 4 (wraps 3 -> 0).
- Loadable with CAND=0: VALID becomes 0. VAL_OUT holds its last value.
- Not loadable: VALID, VAL_OUT and PTR hold. VAL_OUT must stay stable while VALID=1 and READY=0.
- PEND update: PEND_next = CAND with the selected bit cleared if a load occurred, else CAND.
- OVERFLOW_next = |(REQ_IN & PEND). This covers the case where that bit is also being selected this cycle. Only one instance is stored, and the duplicate is dropped.
- A REQ_IN bit equal to the code currently held in the output stage is not an overflow. It is a new pending event.
- States: EMPTY (VALID=0) and FULL (VALID=1).
  - EMPTY -> FULL when CAND!=0.
  - FULL -> FULL on a handshake with CAND!=0, or while READY=0.
  - FULL -> EMPTY on a handshake with CAND=0.

## Timing
- Reset values, applied immediately on RST assertion (asynchronous): VALID=0, VAL_OUT=2'b00, PENDING=4'b0000, OVERFLOW=0, PTR=0.
- Reset asserted mid-operation discards all pending and in-flight events. No handshake completes during reset.
- Latency: REQ_IN sampled at edge n with the stage loadable gives VALID=1 and the code after edge n.
- Throughput: one code per cycle with READY held high. A handshake and the next load happen on the same edge.
- OVERFLOW asserts for one cycle, after the edge on which the colliding REQ_IN was sampled.
- No combinational path from READY or REQ_IN to any output.

## Test plan
- Reset: drive to PENDING=1011, VALID=1. Assert RST between edges. All outputs read 0 before the next edge. After deassertion, outputs stay idle until the first REQ_IN.
- Single event: REQ_IN=0100 for one cycle, READY=1. Next cycle VALID=1, VAL_OUT=10, PENDING=0000. The cycle after that, VALID=0.
- Burst, ROUND_ROBIN=1, PTR=0: REQ_IN=1111 for one cycle, READY=1.
  - VAL_OUT over four consecutive cycles: 00, 01, 10, 11.
  - PENDING over the same cycles: 1110, 1100, 1000, 0000.
  - VALID then drops.
- Backpressure:
  - REQ_IN=0010 for one cycle with READY=0. VALID=1, VAL_OUT=01, stable for 5 cycles.
  - Then REQ_IN=1000 for one cycle. PENDING=1000.
  - Raise READY. The cycle after the handshake shows VAL_OUT=11.
- Overflow: READY=0, REQ_IN=0001 held for 3 cycles.
  - After edge 1: VALID=1, VAL_OUT=00.
  - After edge 2: PENDING=0001.
  - After edge 3: OVERFLOW=1 for exactly one cycle.
  - Then READY=1: exactly two 00 codes are delivered.
- Arbitration:
  - Setup: serve code 00 alone, so PTR=1. Then REQ_IN=0101 for one cycle, READY=1.
  - ROUND_ROBIN=1: codes 10 then 00.
  - ROUND_ROBIN=0: codes 00 then 10.
